// File: rtl/sll_seq.sv
// Multi-cycle logical left shifter: one bit per clock, start/busy/done handshake.
// Trades a barrel shifter for up to 33 cycles of latency on shift amounts 0..31.
module sll_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] opnd;
        logic [SHW-1:0]   amt;
    } req_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [SHW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] res, res_nx;
    req_t             req;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_in2_hi;
    assign unused_in2_hi = ^in2[WIDTH-1:SHW];

    assign req.opnd = in1;
    assign req.amt  = in2[SHW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            res   <= res_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        res_nx   = res;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                    acc_nx   = req.opnd;
                    cnt_nx   = req.amt;
                end
            end
            SHIFT: begin
                // Counter reaching zero costs one extra cycle to publish the result.
                if (cnt != '0) begin
                    acc_nx = {acc[WIDTH-2:0], 1'b0};
                    cnt_nx = cnt - SHW'(1);
                end else begin
                    res_nx   = acc;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign out  = res;

endmodule

// File: tb/tb_sll_seq.sv
// Scoreboard bench for sll_seq: driver pushes expected result/latency, negedge monitor pops on done.
module tb_sll_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] out;

    sll_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc_start;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle checks busy and out-hold; on done pops and checks result and latency.
    always @(negedge clk) begin
        logic exp_busy;
        exp_t e;
        exp_busy = done || (q.size() > 0 && cyc > q[0].cyc_start);
        chk("busy", 32'(busy), 32'(exp_busy));
        if (done) begin
            chk("done_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out", out, e.val);
                chk("latency", 32'(cyc - e.cyc_start), 32'(e.lat + 2));
                last_out = e.val;
            end
        end else begin
            chk("out_hold", out, last_out);
        end
    end

    // Caller sits at a negedge; request is presented as soon as the DUT is idle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int   bud;
        exp_t e;
        bud = 0;
        while (busy && bud < 100) begin
            @(negedge clk);
            bud++;
        end
        if (busy) chk("issue_timeout", 32'(busy), 32'd0);
        start = 1'b1;
        in1   = a;
        in2   = b;
        e.val = expv;
        e.cyc_start = cyc;
        e.lat = int'(b[4:0]);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
    endtask

    task automatic wait_idle();
        int bud;
        bud = 0;
        while ((q.size() > 0 || busy) && bud < 200) begin
            @(negedge clk);
            bud++;
        end
        chk("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        int bud;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out", out, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Basic and boundary shifts
        issue(32'h0000_0001, 32'd4, 32'h0000_0010);
        wait_idle();
        issue(32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'd31, 32'h8000_0000);
        wait_idle();
        issue(32'h1234_5678, 32'h0000_0021, 32'h2468_ACF0);
        wait_idle();
        issue(32'h8000_0001, 32'hFFFF_FFE3, 32'h0000_0008);
        wait_idle();

        // Starts during SHIFT and during DONE must be ignored
        issue(32'h0000_00FF, 32'd8, 32'h0000_FF00);
        repeat (2) @(negedge clk);
        start = 1'b1; in1 = 32'h1; in2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        bud = 0;
        while (!done && bud < 100) begin
            @(negedge clk);
            bud++;
        end
        chk("wait_done", 32'(done), 32'd1);
        start = 1'b1; in1 = 32'h1; in2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        // Accepted in the cycle right after done
        issue(32'h0000_0003, 32'd2, 32'h0000_000C);
        wait_idle();

        // Asynchronous reset mid-operation
        issue(32'h0000_0001, 32'd20, 32'h0010_0000);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        q.delete();
        last_out = '0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out", out, 32'h0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        issue(32'h0000_0005, 32'd3, 32'h0000_0028);
        wait_idle();

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            issue(a, b, a << b[4:0]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sll_seq.md
# sll_seq

Multi-cycle logical left shifter for the RISC processor ALU, complementing the right-shift path. It takes a 32-bit operand `in1` and a shift amount in `in2[4:0]`, and shifts one bit position per clock. Results are returned through a start/busy/done handshake, so the execute stage can stall on `busy` rather than spend area on a full barrel shifter.

## Interface
- `WIDTH`, 32, operand/result width (only 32 is supported)
- `SHW`, 5, shift-amount width taken from `in2[SHW-1:0]`

- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low
- `start`  input  1  request pulse; sampled only in IDLE
- `in1`  input  32  operand to shift; captured when `start` is accepted
- `in2`  input  32  shift amount; only `in2[4:0]` is used, `in2[31:5]` is ignored
- `busy`  output  1  high while in SHIFT or DONE
- `done`  output  1  single-cycle pulse; `out` is valid from this cycle on
- `out`  output  32  registered result; holds its value until the next `done`

## Operation
- States:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1, accumulator `acc` and down-counter `cnt[4:0]` are active.
  - DONE: `busy`=1, `done`=1.
- IDLE → SHIFT when `start`=1.
  - At that edge: `acc` <= `in1`, `cnt` <= `in2[4:0]`.
- In SHIFT, on each edge:
  - If `cnt`≠0: `acc` <= {`acc[30:0]`, 1'b0}, `cnt` <= `cnt`−1.
  - If `cnt`=0: `out` <= `acc`, go to DONE.
- DONE → IDLE unconditionally on the next edge.
- Zero fill only; no sign extension. Bits shifted past bit 31 are discarded.
- `start` while `busy`=1 is ignored. No queuing; the caller must re-issue the request after `done`.
- `start` in the DONE cycle is also ignored. The earliest next accept is the cycle after `done`.
- `in1` and `in2` may change freely after the accept edge.
- `out` changes only on the edge that enters DONE. Between operations it keeps the last result.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `acc`=0, `cnt`=0, `out`=0, `busy`=0, `done`=0.
  - Applies at any point, including mid-SHIFT. The in-flight result is dropped and no `done` is produced.
- Release of `rst` is synchronous to `clk`. The first `start` can be accepted on the first rising edge with `rst`=1.
- Latency for shift amount n (0..31), with the accept edge as E0:
  - Shifts occur on edges E1..En.
  - `out` is loaded and DONE is entered on edge E(n+1).
  - `done` is high in the cycle after E(n+1), i.e. n+2 cycles after the start cycle.
- n=0: one SHIFT cycle, no shift, `done` 2 cycles after start, `out`=`in1`.
- n=31: `done` 33 cycles after start.
- `busy` rises in the cycle after the accept edge and falls in the cycle after `done`.
- Back-to-back throughput: one operation per n+3 cycles.

## Test plan
- Reset state: hold `rst`=0 for 3 cycles → `out`=0, `busy`=0, `done`=0. Release, idle 5 cycles → no change.
- Basic shift: `in1`=32'h0000_0001, `in2`=4, `start` pulse → `done` exactly 6 cycles after start, `out`=32'h0000_0010, `busy` high for 6 cycles.
- Boundaries:
  - `in1`=32'hDEAD_BEEF, `in2`=0 → `out`=32'hDEAD_BEEF, `done` at +2.
  - `in1`=32'hFFFF_FFFF, `in2`=31 → `out`=32'h8000_0000, `done` at +33.
  - `in2`=32'h0000_0021 → treated as shift 1.
- Ignored start: accept `in1`=32'h0000_00FF, `in2`=8. Pulse `start` with `in1`=32'h1, `in2`=1 at +3 and in the DONE cycle → single `done`, `out`=32'h0000_FF00. A start issued the cycle after `done` is accepted.
- Reset mid-op: accept `in2`=20, `in1`=32'h1. Assert `rst` at +7 → `busy`=0 and `out`=0 immediately (asynchronous). No `done` follows. The next operation completes normally.
- Random regression: 1000 random `in1`/`in2` with random idle gaps → every `out` equals (`in1` << `in2[4:0]`), with latency `in2[4:0]`+2.
